// File: rtl/spi_reg_ctrl.sv
// +--------------------------------------------------------------------------+
// | spi_reg_ctrl: SPI byte stream to register bus burst read/write engine.  |
// | Revision 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module spi_reg_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_ss,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  input  logic [DATA_W-1:0] status,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD      = 3'd1,
    S_WR       = 3'd2,
    S_RD_FETCH = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_RD       = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          ss_sync_q, ss_sync_d;
  logic [1:0]          sync_vld_q, sync_vld_d;
  logic                armed_q, armed_d;
  logic                sel_prev_q, sel_prev_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic                bus_we_q, bus_we_d;

  logic sel;
  logic sel_rise;
  logic unused_bits;

  assign sel = ~ss_sync_q[1];
  // A transaction already open when reset releases must not look like a new
  // select edge: only accept a rise once a genuine deselect has been seen.
  assign sel_rise = sel & ~sel_prev_q & armed_q;

  assign unused_bits = &{1'b0, rx_data};

  always_comb begin
    ss_sync_d  = {ss_sync_q[0], spi_ss};
    sync_vld_d = {sync_vld_q[0], 1'b1};
    armed_d    = armed_q | (sync_vld_q[1] & ~sel);
    sel_prev_d = sel;
  end

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_we_d    = 1'b0;

    // Post-write increment is tied to the strobe, so a write that coincides
    // with deselect still advances the address after it completes.
    if (bus_we_q) begin
      bus_addr_d = bus_addr_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_data_d = status;
        if (sel_rise) begin
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (rx_ready) begin
          bus_addr_d = rx_data[ADDR_W-1:0];
          if (rx_data[DATA_W-1]) begin
            state_d   = S_WR;
            tx_data_d = '0;
          end else begin
            state_d = S_RD_FETCH;
          end
        end
      end
      S_WR: begin
        if (rx_ready) begin
          bus_we_d    = 1'b1;
          bus_wdata_d = rx_data;
        end
      end
      S_RD_FETCH: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        tx_data_d = bus_rdata;
        state_d   = S_RD;
      end
      S_RD: begin
        if (tx_ready) begin
          bus_addr_d = bus_addr_q + 1'b1;
          state_d    = S_RD_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!sel && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      ss_sync_q   <= 2'b11;
      sync_vld_q  <= 2'b00;
      armed_q     <= 1'b0;
      sel_prev_q  <= 1'b0;
      tx_data_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ss_sync_q   <= ss_sync_d;
      sync_vld_q  <= sync_vld_d;
      armed_q     <= armed_d;
      sel_prev_q  <= sel_prev_d;
      tx_data_q   <= tx_data_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_we_q    <= bus_we_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_we    = bus_we_q;
  // Read strobe is decoded from state so read data lands one cycle later,
  // exactly when RD_WAIT latches it; suppressed once deselect is visible.
  assign bus_re    = (state_q == S_RD_FETCH) & sel;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_spi_reg_ctrl: directed bench for spi_reg_ctrl byte/bus behaviour.    |
// | Revision 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_spi_reg_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk;
  logic              resetn;
  logic              spi_ss;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] status;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_we;
  logic              bus_re;
  logic [DATA_W-1:0] bus_rdata;
  logic              busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] we_addr_q[$];
  logic [7:0] we_data_q[$];
  logic [7:0] re_addr_q[$];

  spi_reg_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .spi_ss   (spi_ss),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .status   (status),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_we   (bus_we),
    .bus_re   (bus_re),
    .bus_rdata(bus_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: reg[n] = 0x40 + n, data valid the cycle after bus_re.
  always @(posedge clk) begin
    if (bus_re) bus_rdata <= 8'h40 + {4'h0, bus_addr};
  end

  always @(negedge clk) begin
    if (bus_we) begin
      we_addr_q.push_back({4'h0, bus_addr});
      we_data_q.push_back(bus_wdata);
    end
    if (bus_re) re_addr_q.push_back({4'h0, bus_addr});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_data  = d;
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic tx_pulse(output logic [7:0] miso);
    miso     = tx_data;
    tx_ready = 1'b1;
    cyc(1);
    tx_ready = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] mosi, output logic [7:0] miso);
    tx_pulse(miso);
    cyc(6);
    rx_pulse(mosi);
    cyc(6);
  endtask

  task automatic select_ss();
    spi_ss = 1'b0;
    cyc(4);
  endtask

  task automatic deselect_ss();
    spi_ss = 1'b1;
    cyc(5);
  endtask

  task automatic clear_queues();
    we_addr_q.delete();
    we_data_q.delete();
    re_addr_q.delete();
  endtask

  initial begin
    logic [7:0] m;
    spi_ss   = 1'b1;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    tx_ready = 1'b0;
    status   = 8'hA5;
    resetn   = 1'b0;
    cyc(3);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_bus_addr", bus_addr, 4'h0);
    chk("rst_bus_wdata", bus_wdata, 8'h00);
    chk("rst_bus_we", bus_we, 1'b0);
    chk("rst_bus_re", bus_re, 1'b0);
    chk("rst_busy", busy, 1'b0);
    resetn = 1'b1;
    cyc(6);
    chk("idle_tx_status", tx_data, 8'hA5);

    // Status readback: one byte shifted out, no complete byte received.
    clear_queues();
    select_ss();
    chk("stat_busy_sel", busy, 1'b1);
    tx_pulse(m);
    chk("stat_miso", m, 8'hA5);
    cyc(6);
    spi_ss = 1'b1;
    cyc(2);
    chk("stat_busy_2cyc", busy, 1'b1);
    cyc(1);
    chk("stat_busy_3cyc", busy, 1'b0);
    cyc(3);
    chk("stat_no_we", we_addr_q.size(), 0);
    chk("stat_no_re", re_addr_q.size(), 0);

    // Write burst 0x83: 0x11@3, 0x22@4, 0x33@5.
    clear_queues();
    select_ss();
    xfer(8'h83, m);
    xfer(8'h11, m);
    chk("wr_miso_zero", m, 8'h00);
    xfer(8'h22, m);
    xfer(8'h33, m);
    deselect_ss();
    chk("wr_count", we_addr_q.size(), 3);
    if (we_addr_q.size() == 3) begin
      chk("wr0_addr", we_addr_q[0], 8'h03);
      chk("wr0_data", we_data_q[0], 8'h11);
      chk("wr1_addr", we_addr_q[1], 8'h04);
      chk("wr1_data", we_data_q[1], 8'h22);
      chk("wr2_addr", we_addr_q[2], 8'h05);
      chk("wr2_data", we_data_q[2], 8'h33);
    end
    chk("wr_final_addr", bus_addr, 4'h6);
    chk("wr_no_re", re_addr_q.size(), 0);

    // Write wrap 0x8F: 0xAA@15, 0xBB@0.
    clear_queues();
    select_ss();
    xfer(8'h8F, m);
    xfer(8'hAA, m);
    xfer(8'hBB, m);
    deselect_ss();
    chk("wrap_count", we_addr_q.size(), 2);
    if (we_addr_q.size() == 2) begin
      chk("wrap0_addr", we_addr_q[0], 8'h0F);
      chk("wrap0_data", we_data_q[0], 8'hAA);
      chk("wrap1_addr", we_addr_q[1], 8'h00);
      chk("wrap1_data", we_data_q[1], 8'hBB);
    end

    // Read burst 0x02 with exact prefetch latency.
    clear_queues();
    status = 8'h3C;
    cyc(2);
    select_ss();
    tx_pulse(m);
    chk("rd_cmd_miso", m, 8'h3C);
    cyc(6);
    rx_pulse(8'h02);
    cyc(1);
    chk("rd_lat_2", tx_data, 8'h3C);
    cyc(1);
    chk("rd_lat_3", tx_data, 8'h42);
    cyc(4);
    xfer(8'h00, m);
    chk("rd_byte0", m, 8'h42);
    xfer(8'h00, m);
    chk("rd_byte1", m, 8'h43);
    xfer(8'h00, m);
    chk("rd_byte2", m, 8'h44);
    deselect_ss();
    chk("rd_re_count", re_addr_q.size(), 4);
    if (re_addr_q.size() == 4) begin
      chk("rd_re0", re_addr_q[0], 8'h02);
      chk("rd_re1", re_addr_q[1], 8'h03);
      chk("rd_re2", re_addr_q[2], 8'h04);
      chk("rd_re3", re_addr_q[3], 8'h05);
    end
    chk("rd_no_we", we_addr_q.size(), 0);

    // Abort mid second byte of a write, then a normal write.
    clear_queues();
    select_ss();
    xfer(8'h84, m);
    tx_pulse(m);
    cyc(4);
    deselect_ss();
    chk("abort_no_we", we_addr_q.size(), 0);
    chk("abort_idle", busy, 1'b0);
    select_ss();
    xfer(8'h81, m);
    xfer(8'h5A, m);
    deselect_ss();
    chk("abort_wr_count", we_addr_q.size(), 1);
    if (we_addr_q.size() == 1) begin
      chk("abort_wr_addr", we_addr_q[0], 8'h01);
      chk("abort_wr_data", we_data_q[0], 8'h5A);
    end

    // Reset during RD, release with spi_ss still low.
    clear_queues();
    select_ss();
    xfer(8'h02, m);
    tx_pulse(m);
    cyc(4);
    chk("rst_pre_tx", tx_data, 8'h43);
    resetn = 1'b0;
    #1;
    chk("arst_tx_data", tx_data, 8'h00);
    chk("arst_bus_re", bus_re, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_bus_addr", bus_addr, 4'h0);
    cyc(2);
    resetn = 1'b1;
    cyc(2);
    clear_queues();
    cyc(8);
    xfer(8'h85, m);
    xfer(8'h77, m);
    tx_pulse(m);
    cyc(6);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_no_we", we_addr_q.size(), 0);
    chk("post_rst_no_re", re_addr_q.size(), 0);
    deselect_ss();
    select_ss();
    xfer(8'h83, m);
    xfer(8'h99, m);
    deselect_ss();
    chk("post_rst_wr_count", we_addr_q.size(), 1);
    if (we_addr_q.size() == 1) begin
      chk("post_rst_wr_addr", we_addr_q[0], 8'h03);
      chk("post_rst_wr_data", we_data_q[0], 8'h99);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Byte-level transaction controller that sits between the SPI slave byte interface (txdata/rxdata/rxready/txready) and an internal register bus.
- Decodes a command byte and runs burst reads or writes with address auto-increment.
- Prefetches read data so it is ready before the slave captures the next transmit byte.
- Drives a status byte on the first byte of every transaction.

Parameters:
- ADDR_W, 4, register address width; the address space is 2^ADDR_W byte registers.
- DATA_W, 8, data width; must equal the slave WIDTH.

Ports:
- clk  in  1  system clock, same clock as the SPI slave.
- resetn  in  1  asynchronous active-low reset.
- spi_ss  in  1  raw SPI slave-select, active low, unsynchronised.
- rx_data  in  DATA_W  byte received from the slave.
- rx_ready  in  1  rx_data valid this cycle, 1-cycle pulse.
- tx_ready  in  1  slave captured tx_data this cycle, 1-cycle pulse.
- tx_data  out  DATA_W  next byte for the slave to shift out; registered.
- status  in  DATA_W  status byte returned during the command byte.
- bus_addr  out  ADDR_W  register address.
- bus_wdata  out  DATA_W  write data.
- bus_we  out  1  write strobe, 1 cycle.
- bus_re  out  1  read strobe, 1 cycle; bus_rdata is valid exactly 1 cycle later.
- bus_rdata  in  DATA_W  read data.
- busy  out  1  high while a transaction is open (state is not IDLE).

Behaviour:
- Reset values: tx_data=0, bus_addr=0, bus_wdata=0, bus_we=0, bus_re=0, busy=0, state=IDLE.
- Select synchronisation:
  - spi_ss passes through a 2-flop synchroniser; sel = ~ss_sync[1].
  - The synchroniser depth matches the slave, so both see deselect on the same cycle.
- Command byte format:
  - bit7=1 means write, bit7=0 means read.
  - bits[ADDR_W-1:0] give the start address.
  - Remaining bits are ignored.
- States: IDLE, CMD, WR, RD_FETCH, RD_WAIT, RD.
- IDLE:
  - tx_data is held equal to status every cycle, so the first byte always returns the current status.
  - sel rising moves to CMD.
- CMD:
  - On rx_ready, load bus_addr from the command byte.
  - Write command: go to WR and set tx_data=0.
  - Read command: go to RD_FETCH.
  - The tx_ready pulse of the first byte is ignored in this state.
- WR:
  - Each rx_ready drives bus_we=1 for exactly one cycle, with bus_wdata=rx_data and the current bus_addr.
  - The cycle after the strobe, bus_addr increments modulo 2^ADDR_W, so address 2^ADDR_W-1 wraps to 0.
  - tx_data stays 0.
  - tx_ready in WR has no effect.
- RD_FETCH:
  - Assert bus_re=1 for one cycle at the current bus_addr, then go to RD_WAIT.
- RD_WAIT:
  - Latch tx_data <= bus_rdata, then go to RD.
  - Total latency from command rx_ready to tx_data valid is 3 clk cycles.
  - This is well inside one SCK period, since SCK is at least 8 clk periods through the slave synchroniser.
- RD:
  - On tx_ready, increment bus_addr (with wrap) and go to RD_FETCH to prefetch the next byte.
  - rx_ready in RD is ignored, because master bytes during a read are don't-care.
  - Because the prefetch follows tx_ready, a byte is always fetched beyond the last one clocked out. This over-read is permitted, as registers have no read side effects.
- Deselect:
  - sel low in any state returns to IDLE on the next cycle.
  - Any pending bus_re/bus_we that was already issued completes; no new strobe is issued.
  - A partially shifted byte is discarded, since the slave never raises rx_ready for it.
- Simultaneous events:
  - If deselect occurs on the same cycle as rx_ready in WR, the write is still performed, then the block goes to IDLE.
  - If rx_ready and tx_ready arrive together, rx_ready is processed in CMD/WR and tx_ready in RD; each state only looks at its own event.
- Asynchronous reset mid-transaction:
  - All outputs return immediately to their reset values and the synchroniser clears to "deselected".
  - After reset is released, the block waits for a fresh sel rising edge; a transaction still in progress at release is ignored until deselect.
- busy = (state != IDLE).

Test Plan:
- Status readback: status=0xA5, select, shift one byte -> master receives 0xA5; no bus_we or bus_re pulse; busy high while selected, low 3 cycles after deselect.
- Write burst: command 0x83 then data 0x11, 0x22, 0x33 -> three single-cycle bus_we pulses at addr 3, 4, 5 with wdata 0x11, 0x22, 0x33; final bus_addr=6.
- Write wrap (ADDR_W=4): command 0x8F then 0xAA, 0xBB -> writes 0xAA@15 and 0xBB@0.
- Read burst: register model holds reg[n]=0x40+n; command 0x02 then 3 dummy bytes -> master receives 0x42, 0x43, 0x44; bus_re pulses at 2, 3, 4, 5 (the read at 5 is the prefetch over-read).
- Abort: deassert spi_ss after 4 bits of the second byte of a write -> no bus_we; state IDLE; the next transaction with command 0x81 then 0x5A writes 0x5A@1 normally.
- Reset mid-read: assert resetn=0 during RD -> tx_data=0, bus_re=0 and busy=0 immediately; after release with spi_ss still low, no bus activity until spi_ss goes high then low.
